// File: rtl/mem_master.sv
// Byte-wide memory master: turns CPU byte/word requests into little-endian byte cycles
// on an 8-bit bidirectional bus. Word accesses are enabled by defining MEM_MASTER_WORD_EN.
`timescale 1ns/1ps

module mem_master #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_word,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    output logic [15:0]           resp_rdata,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [7:0]            mem_data
);

`ifdef MEM_MASTER_WORD_EN
    localparam logic WORD_EN = 1'b1;
`else
    localparam logic WORD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, WR_LO, WR_HI, RD_LO, CAP_LO, RD_HI, CAP_HI, DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  word_q;
    logic                  word_nxt;
    logic [7:0]            wdata_hi_q;
    logic [7:0]            wdata_hi_nxt;
    logic [7:0]            rd_lo_q;
    logic [7:0]            rd_lo_nxt;
    logic                  drive_q;
    logic                  drive_nxt;
    logic [7:0]            dout_q;
    logic [7:0]            dout_nxt;
    logic                  ready_nxt;
    logic                  valid_nxt;
    logic                  rw_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [15:0]           rdata_nxt;

    // Bus is released whenever the registered drive enable is low (including reset).
    assign mem_data = drive_q ? dout_q : 8'hzz;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_we ? WR_LO : RD_LO;
            WR_LO:   state_nxt = word_q ? WR_HI : DONE;
            WR_HI:   state_nxt = DONE;
            RD_LO:   state_nxt = CAP_LO;
            CAP_LO:  state_nxt = word_q ? RD_HI : DONE;
            RD_HI:   state_nxt = CAP_HI;
            CAP_HI:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the next state
    always_comb begin
        ready_nxt    = (state_nxt == IDLE);
        valid_nxt    = (state_nxt == DONE);
        rw_nxt       = (state_nxt == WR_LO) || (state_nxt == WR_HI);
        drive_nxt    = rw_nxt;
        addr_nxt     = mem_addr;
        dout_nxt     = dout_q;
        rdata_nxt    = resp_rdata;
        rd_lo_nxt    = rd_lo_q;
        word_nxt     = word_q;
        wdata_hi_nxt = wdata_hi_q;

        if ((state == IDLE) && req_valid) begin
            word_nxt     = req_word & WORD_EN;
            wdata_hi_nxt = req_wdata[15:8];
        end

        // The low-byte phases are only entered from IDLE, so the request fields are live
        case (state_nxt)
            WR_LO: begin
                addr_nxt = req_addr;
                dout_nxt = req_wdata[7:0];
            end
            RD_LO:   addr_nxt = req_addr;
            WR_HI: begin
                addr_nxt = mem_addr + ADDR_WIDTH'(1);
                dout_nxt = wdata_hi_q;
            end
            RD_HI:   addr_nxt = mem_addr + ADDR_WIDTH'(1);
            default: ;
        endcase

        // Read data is committed only on entry to DONE so resp_rdata never shows a partial word
        if (state == CAP_LO) begin
            if (word_q) begin
                rd_lo_nxt = mem_data;
            end else begin
                rdata_nxt = {8'h00, mem_data};
            end
        end
        if (state == CAP_HI) begin
            rdata_nxt = {mem_data, rd_lo_q};
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 16'h0000;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            drive_q    <= 1'b0;
            dout_q     <= 8'h00;
            rd_lo_q    <= 8'h00;
            word_q     <= 1'b0;
            wdata_hi_q <= 8'h00;
        end else begin
            req_ready  <= ready_nxt;
            resp_valid <= valid_nxt;
            resp_rdata <= rdata_nxt;
            mem_rw     <= rw_nxt;
            mem_addr   <= addr_nxt;
            drive_q    <= drive_nxt;
            dout_q     <= dout_nxt;
            rd_lo_q    <= rd_lo_nxt;
            word_q     <= word_nxt;
            wdata_hi_q <= wdata_hi_nxt;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: byte-array memory on the bus, a per-cycle transaction model,
// and directed requests with literal expectations. Honours MEM_MASTER_WORD_EN.
`timescale 1ns/1ps

module tb_mem_master;

`ifdef MEM_MASTER_WORD_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_word;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        mem_rw;
    logic [15:0] mem_addr;
    wire  [7:0]  mem_data;

    logic        mem_oe;
    logic [7:0]  mem_q;
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    // Memory drives its registered read data only while the model says a capture is due
    assign mem_data = mem_oe ? mem_q : 8'hzz;
    pullup (mem_data);

    mem_master #(.ADDR_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_word   (req_word),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rw;
        bit          drv;
        bit          cap;
        bit          done;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] rdata;
    } cyc_t;

    cyc_t        exp_q[$];
    cyc_t        idle_rec;
    logic [15:0] model_rdata;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(bit rw, bit cap, bit done, logic [15:0] a,
                                logic [7:0] d, logic [15:0] rd);
        cyc_t c;
        c.rw    = rw;
        c.drv   = rw;
        c.cap   = cap;
        c.done  = done;
        c.addr  = a;
        c.data  = d;
        c.rdata = rd;
        return c;
    endfunction

    // Queue the cycle-by-cycle picture of one accepted request
    task automatic expect_txn(bit we, bit word, logic [15:0] a, logic [15:0] wd);
        logic [15:0] a1;
        logic [15:0] old;
        logic [15:0] nr;
        bit          w;
        a1  = a + 16'd1;
        old = model_rdata;
        w   = word && WE;
        if (we) begin
            exp_q.push_back(mk(1, 0, 0, a, wd[7:0], old));
            if (w) exp_q.push_back(mk(1, 0, 0, a1, wd[15:8], old));
            exp_q.push_back(mk(0, 0, 1, w ? a1 : a, 8'h00, old));
        end else begin
            nr = w ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
            exp_q.push_back(mk(0, 0, 0, a, 8'h00, old));
            exp_q.push_back(mk(0, 1, 0, a, 8'h00, old));
            if (w) begin
                exp_q.push_back(mk(0, 0, 0, a1, 8'h00, old));
                exp_q.push_back(mk(0, 1, 0, a1, 8'h00, old));
            end
            exp_q.push_back(mk(0, 0, 1, w ? a1 : a, 8'h00, nr));
            model_rdata = nr;
        end
    endtask

    // Memory, model advance and the per-cycle comparison
    always @(posedge clk) begin
        cyc_t r;
        bit   acc;
        logic [7:0] bus_exp;
        acc = rst_n && req_valid && (exp_q.size() == 0);
        cyc++;
        if (mem_rw) mem[mem_addr] = mem_data;
        mem_q <= mem[mem_addr];
        if (!rst_n) begin
            exp_q.delete();
            idle_rec    = mk(0, 0, 0, 16'h0000, 8'h00, 16'h0000);
            model_rdata = 16'h0000;
        end else begin
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                if (r.rw) ref_mem[r.addr] = r.data;
                idle_rec.addr  = r.addr;
                idle_rec.rdata = r.rdata;
            end
            if (acc) expect_txn(req_we, req_word, req_addr, req_wdata);
        end
        mem_oe <= (exp_q.size() != 0) && exp_q[0].cap;
        #1;
        r = (exp_q.size() != 0) ? exp_q[0] : idle_rec;
        bus_exp = r.drv ? r.data : (r.cap ? mem_q : 8'hFF);
        chk("req_ready",  req_ready,  exp_q.size() == 0);
        chk("resp_valid", resp_valid, r.done);
        chk("mem_rw",     mem_rw,     r.rw);
        chk("mem_addr",   mem_addr,   r.addr);
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("mem_data",   mem_data,   bus_exp);
    end

    task automatic do_req(input bit we, input bit word, input logic [15:0] a,
                          input logic [15:0] wd, input bit hold,
                          output int lat, output int acc_cyc, output logic [15:0] rd);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_word  = word;
        req_addr  = a;
        req_wdata = wd;
        lat = 0;
        acc_cyc = 0;
        rd = 16'h0000;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        // Scramble the request fields after acceptance; the access must not notice
        req_valid = hold;
        req_we    = ~we;
        req_word  = ~word;
        req_addr  = ~a;
        req_wdata = ~wd;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
        rd = resp_rdata;
    endtask

    initial begin
        int          lat;
        int          acc1;
        int          acc2;
        logic [15:0] rd;

        rst_n = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_word = 1'b0;
        req_addr = 16'h0000;
        req_wdata = 16'h0000;
        mem_oe = 1'b0;
        mem_q = 8'h00;
        model_rdata = 16'h0000;
        idle_rec = mk(0, 0, 0, 16'h0000, 8'h00, 16'h0000);
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = mem[i];
        end
        mem[16'h0020] = 8'h34; ref_mem[16'h0020] = 8'h34;
        mem[16'h0021] = 8'h12; ref_mem[16'h0021] = 8'h12;
        mem[16'h0005] = 8'h7E; ref_mem[16'h0005] = 8'h7E;

        #1 rst_n = 1'b0;
        #1;
        chk("reset_ready", req_ready, 1);
        chk("reset_valid", resp_valid, 0);
        chk("reset_rdata", resp_rdata, 16'h0000);
        chk("reset_rw",    mem_rw, 0);
        chk("reset_addr",  mem_addr, 16'h0000);
        chk("reset_bus",   mem_data, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req(1, 0, 16'h0010, 16'h00A5, 0, lat, acc1, rd);
        chk("bw_latency", lat, 2);
        chk("bw_mem",     mem[16'h0010], 8'hA5);

        do_req(0, 1, 16'h0020, 16'h0000, 0, lat, acc1, rd);
        chk("wr_rdata",   rd, WE ? 16'h1234 : 16'h0034);
        chk("wr_latency", lat, WE ? 5 : 3);

        do_req(1, 1, 16'hFFFF, 16'hBEEF, 0, lat, acc1, rd);
        chk("ww_latency", lat, WE ? 3 : 2);
        chk("wrap_lo",    mem[16'hFFFF], 8'hEF);
        chk("wrap_hi",    mem[16'h0000], WE ? 8'hBE : 8'h5A);

        do_req(0, 0, 16'h0005, 16'h0000, 1, lat, acc1, rd);
        chk("br_rdata",   rd, 16'h007E);
        chk("br_latency", lat, 3);
        do_req(0, 0, 16'h0010, 16'h0000, 0, lat, acc2, rd);
        chk("b2b_gap",    acc2 - acc1, 4);
        chk("b2b_rdata",  rd, 16'h00A5);

        do_req(1, 1, 16'h0040, 16'h1357, 0, lat, acc1, rd);
        do_req(0, 1, 16'h0040, 16'h0000, 0, lat, acc1, rd);
        chk("rt_rdata",   rd, WE ? 16'h1357 : 16'h0057);

        // Reset in the middle of a word write
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_word  = 1'b1;
        req_addr  = 16'h0080;
        req_wdata = 16'hC3D2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rw",    mem_rw, 0);
        chk("rst_bus",   mem_data, 8'hFF);
        chk("rst_valid", resp_valid, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_addr",  mem_addr, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rel_no_resp", resp_valid, 0);
        end
        chk("rst_mem_lo", mem[16'h0080], 8'hD2);
        chk("rst_mem_hi", mem[16'h0081], 8'hDB);

        do_req(0, 0, 16'h0080, 16'h0000, 0, lat, acc1, rd);
        chk("post_rdata", rd, 16'h00D2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
